// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, fault codes, access-size encodings.
package load_store_unit_pkg;
  localparam int LSU_XLEN = 32;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    LSU_FAULT_NONE  = 2'b00,
    LSU_FAULT_ALIGN = 2'b01,
    LSU_FAULT_BUS   = 2'b10
  } lsu_fault_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port: single-outstanding request/ready bus between the LSU (master) and memory (slave).
interface load_store_unit_if #(parameter int XLEN = 32);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering: store replication/enables, load extract with sign/zero
// extension, and an illegal flag for reserved encodings or misaligned halfword/word accesses.
module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            illegal_o
);
  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted     = mem_rdata_i >> {addr_lo_i, 3'b000};
    wdata_o     = store_data_i;
    be_o        = 4'b1111;
    load_data_o = shifted;
    illegal_o   = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        wdata_o     = {4{store_data_i[7:0]}};
        be_o        = 4'b0001 << addr_lo_i;
        load_data_o = {{(XLEN-8){(funct3_i == F3_B) & shifted[7]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        wdata_o     = {2{store_data_i[15:0]}};
        be_o        = 4'b0011 << addr_lo_i;
        load_data_o = {{(XLEN-16){(funct3_i == F3_H) & shifted[15]}}, shifted[15:0]};
        illegal_o   = addr_lo_i[0];
      end
      F3_W: begin
        illegal_o = |addr_lo_i;
      end
      default: begin
        load_data_o = '0;
        illegal_o   = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one memory access per EXEC, stalls the control unit until it completes,
// and holds the extended load result for writeback. The request overlaps the start cycle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN           = LSU_XLEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     dbus_re,
  input  logic                     dbus_we,
  input  logic [2:0]               funct3,
  input  logic [XLEN-1:0]          addr,
  input  logic [XLEN-1:0]          store_data,
  load_store_unit_if.master        mem,
  output logic                     stall,
  output logic [XLEN-1:0]          load_data,
  output logic                     load_valid,
  output logic [1:0]               fault
);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  lsu_state_t      state_q, state_d;
  lsu_fault_t      fault_q, fault_d;
  logic [XLEN-1:0] addr_q, addr_d, sdata_q, sdata_d, load_data_q, load_data_d;
  logic [2:0]      f3_q, f3_d;
  logic            we_q, we_d, ld_q, ld_d;
  logic [WD_W-1:0] wd_q, wd_d, wd_nxt;

  logic            in_idle, start, bad, issue, timeout;
  logic [XLEN-1:0] cur_addr, cur_sdata, la_wdata, la_load;
  logic [2:0]      cur_f3;
  logic [3:0]      la_be;
  logic            cur_we, la_illegal;

  // In IDLE the lane logic looks at the live inputs so the request can go out in the start cycle.
  assign in_idle   = (state_q == LSU_IDLE);
  assign start     = rst & in_idle & en & (dbus_re | dbus_we);
  assign cur_addr  = in_idle ? addr       : addr_q;
  assign cur_sdata = in_idle ? store_data : sdata_q;
  assign cur_f3    = in_idle ? funct3     : f3_q;
  assign cur_we    = in_idle ? dbus_we    : we_q;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .funct3_i     (cur_f3),
    .addr_lo_i    (cur_addr[1:0]),
    .store_data_i (cur_sdata),
    .mem_rdata_i  (mem.mem_rdata),
    .wdata_o      (la_wdata),
    .be_o         (la_be),
    .load_data_o  (la_load),
    .illegal_o    (la_illegal)
  );

  assign bad     = la_illegal | (dbus_re & dbus_we) | (dbus_we & funct3[2]);
  assign issue   = (start & ~bad) | (state_q == LSU_REQ);
  assign wd_nxt  = (in_idle ? '0 : wd_q) + WD_W'(1);
  assign timeout = (TIMEOUT_CYCLES != 0) && (wd_nxt == WD_W'(TIMEOUT_CYCLES));

  assign mem.mem_req   = issue;
  assign mem.mem_we    = issue & cur_we;
  assign mem.mem_addr  = issue ? {cur_addr[XLEN-1:2], 2'b00} : '0;
  assign mem.mem_wdata = issue ? la_wdata : '0;
  assign mem.mem_be    = issue ? la_be : 4'b0000;
  assign load_data     = load_data_q;
  assign fault         = fault_q;

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    f3_d        = f3_q;
    we_d        = we_q;
    ld_d        = ld_q;
    wd_d        = wd_q;
    load_data_d = load_data_q;
    stall       = 1'b0;
    load_valid  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          addr_d  = addr;
          sdata_d = store_data;
          f3_d    = funct3;
          we_d    = dbus_we;
          ld_d    = dbus_re;
          wd_d    = '0;
          if (bad) begin
            state_d = LSU_DONE;
            fault_d = LSU_FAULT_ALIGN;
          end else if (mem.mem_ready) begin
            state_d = LSU_DONE;
            if (dbus_re) load_data_d = la_load;
          end else if (timeout) begin
            state_d = LSU_DONE;
            fault_d = LSU_FAULT_BUS;
          end else begin
            state_d = LSU_REQ;
            wd_d    = wd_nxt;
          end
        end
      end
      LSU_REQ: begin
        stall = 1'b1;
        if (mem.mem_ready) begin
          state_d = LSU_DONE;
          if (ld_q) load_data_d = la_load;
        end else if (timeout) begin
          state_d = LSU_DONE;
          fault_d = LSU_FAULT_BUS;
        end else begin
          wd_d = wd_nxt;
        end
      end
      LSU_DONE: begin
        load_valid = ld_q && (fault_q == LSU_FAULT_NONE);
        if (!en) begin
          state_d = LSU_IDLE;
          fault_d = LSU_FAULT_NONE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LSU_IDLE;
      fault_q     <= LSU_FAULT_NONE;
      addr_q      <= '0;
      sdata_q     <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      ld_q        <= 1'b0;
      wd_q        <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      ld_q        <= ld_d;
      wd_q        <= wd_d;
      load_data_q <= load_data_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a per-access behavioural model sets the expected outputs
// every cycle, a negedge process compares them, and literal checks pin the model's key results.
module tb_load_store_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, dbus_re, dbus_we;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, load_valid;
  logic [31:0] load_data;
  logic [1:0]  fault;

  load_store_unit_if #(.XLEN(32)) mif ();

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .dbus_re(dbus_re), .dbus_we(dbus_we),
    .funct3(funct3), .addr(addr), .store_data(store_data), .mem(mif),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  bit          chk_en = 1'b0;
  bit          exp_req, exp_we, exp_stall, exp_lv;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_be;
  logic [1:0]  exp_fault;

  int          stall_cnt = 0, req_cnt = 0, lv_cnt = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [1:0]  last_fault = 2'b00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (from the access rules) ----------------
  function automatic int m_bytes(input logic [2:0] f3);
    return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int v;
    v = ((1 << m_bytes(f3)) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (m_bytes(f3))
      1:       return (sd & 32'hFF) * 32'h0101_0101;
      2:       return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh, v;
    sh = rd >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v | 32'hFFFF_FF00; end
      3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v | 32'hFFFF_0000; end
      3'd4: v = sh & 32'hFF;
      3'd5: v = sh & 32'hFFFF;
      default: v = sh;
    endcase
    return v;
  endfunction

  function automatic bit m_illegal(input bit re, input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (re && we) return 1'b1;
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if (f3 % 4 == 1 && a % 2 != 0) return 1'b1;
    if (f3 % 4 == 2 && a % 4 != 0) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", 32'(mif.mem_req), 32'(exp_req));
      if (exp_req) begin
        chk("mem_we", 32'(mif.mem_we), 32'(exp_we));
        chk("mem_addr", mif.mem_addr, exp_addr);
        chk("mem_be", 32'(mif.mem_be), 32'(exp_be));
        if (exp_we) chk("mem_wdata", mif.mem_wdata, exp_wdata);
      end
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("load_valid", 32'(load_valid), 32'(exp_lv));
      chk("fault", 32'(fault), 32'(exp_fault));
      chk("load_data", load_data, exp_ld);
    end
    if (mif.mem_req) begin
      req_cnt++;
      cap_addr  = mif.mem_addr;
      cap_wdata = mif.mem_wdata;
      cap_be    = mif.mem_be;
      cap_we    = mif.mem_we;
    end
    if (stall) stall_cnt++;
    if (load_valid) lv_cnt++;
    if (fault != 2'b00) last_fault = fault;
  end

  int s0, r0, l0;

  // waits < 0 means memory never answers; hold = extra DONE cycles with en still high.
  task automatic access(input bit re, input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int waits, input int hold);
    bit ill, got_ready, done;
    int k;
    logic [1:0] f;
    s0 = stall_cnt; r0 = req_cnt; l0 = lv_cnt;
    ill = m_illegal(re, we, f3, a);
    en = 1'b1; dbus_re = re; dbus_we = we; funct3 = f3; addr = a; store_data = sd;
    mif.mem_rdata = rd;
    exp_stall = 1'b1; exp_lv = 1'b0; exp_fault = 2'b00;
    got_ready = 1'b0;
    if (ill) begin
      exp_req = 1'b0; mif.mem_ready = 1'b0;
      @(posedge clk); #1;
    end else begin
      k = 0; done = 1'b0;
      while (!done) begin
        exp_req = 1'b1; exp_we = we; exp_addr = a & 32'hFFFF_FFFC;
        exp_be = m_be(f3, a); exp_wdata = m_wdata(f3, sd);
        mif.mem_ready = (waits >= 0) && (k == waits);
        @(posedge clk); #1;
        got_ready = mif.mem_ready;
        k++;
        if (got_ready || k == TMO) done = 1'b1;
      end
    end
    mif.mem_ready = 1'b0;
    f = ill ? 2'b01 : (got_ready ? 2'b00 : 2'b10);
    if (re && f == 2'b00) exp_ld = m_load(f3, a, rd);
    exp_req = 1'b0; exp_stall = 1'b0; exp_fault = f; exp_lv = re && (f == 2'b00);
    repeat (hold) begin @(posedge clk); #1; end
    en = 1'b0; dbus_re = 1'b0; dbus_we = 1'b0;
    @(posedge clk); #1;
    exp_fault = 2'b00; exp_lv = 1'b0;
    mif.mem_ready = 1'b1;  // stray ready while idle must be ignored
    @(posedge clk); #1;
    mif.mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dbus_re = 1'b0; dbus_we = 1'b0; funct3 = 3'd0;
    addr = '0; store_data = '0; mif.mem_ready = 1'b0; mif.mem_rdata = '0;
    exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0; exp_lv = 1'b0;
    exp_fault = 2'b00; exp_ld = '0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    #12;
    chk("rst mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst load_data", load_data, 32'd0);
    chk("rst load_valid", 32'(load_valid), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 0);
    chk("LW stall cycles", 32'(stall_cnt - s0), 32'd3);
    chk("LW mem_addr", cap_addr, 32'h100);
    chk("LW be", 32'(cap_be), 32'hF);
    chk("LW load_data", load_data, 32'hDEAD_BEEF);
    chk("LW valid cycles", 32'(lv_cnt - l0), 32'd1);

    access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 1, 0);
    chk("LB sext", load_data, 32'hFFFF_FF80);
    access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 1);
    chk("LBU zext", load_data, 32'h0000_0080);
    chk("LBU valid cycles", 32'(lv_cnt - l0), 32'd2);
    access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF_FFFF, 1, 0);
    chk("LHU zext", load_data, 32'h0000_80FF);

    access(0, 1, 3'b001, 32'h206, 32'h1234_ABCD, 32'h0, 1, 0);
    chk("SH mem_addr", cap_addr, 32'h204);
    chk("SH wdata", cap_wdata, 32'hABCD_ABCD);
    chk("SH be", 32'(cap_be), 32'hC);
    chk("SH we", 32'(cap_we), 32'd1);
    chk("SH no load_valid", 32'(lv_cnt - l0), 32'd0);

    access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
    chk("LW misaligned no req", 32'(req_cnt - r0), 32'd0);
    chk("LW misaligned fault", 32'(last_fault), 32'd1);
    access(1, 0, 3'b001, 32'h103, 32'h0, 32'h0, 0, 0);

    access(1, 0, 3'b010, 32'h300, 32'h0, 32'h5555_5555, -1, 0);
    chk("timeout req cycles", 32'(req_cnt - r0), 32'd4);
    chk("timeout fault", 32'(last_fault), 32'd2);
    chk("timeout load_data kept", load_data, 32'h0000_80FF);

    access(0, 1, 3'b010, 32'h208, 32'hCAFE_F00D, 32'h0, 0, 0);
    chk("SW zero-wait stall", 32'(stall_cnt - s0), 32'd1);
    access(0, 1, 3'b000, 32'h201, 32'h0000_00A5, 32'h0, 0, 0);
    chk("SB wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("SB be", 32'(cap_be), 32'h2);
    access(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 1, 0);
    chk("LH sext", load_data, 32'hFFFF_8001);
    access(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0);
    access(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0);
    access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
    access(1, 0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 0);
    chk("illegal keeps load_data", load_data, 32'hFFFF_8001);

    // reset in the middle of a request
    en = 1'b1; dbus_re = 1'b1; dbus_we = 1'b0; funct3 = 3'b010; addr = 32'h400;
    mif.mem_ready = 1'b0;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h400; exp_be = 4'hF; exp_stall = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #2;
    chk_en = 1'b0;
    rst = 1'b0; #1;
    chk("rst-in-REQ mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst-in-REQ stall", 32'(stall), 32'd0);
    chk("rst-in-REQ load_data", load_data, 32'd0);
    chk("rst-in-REQ fault", 32'(fault), 32'd0);
    en = 1'b0; dbus_re = 1'b0;
    exp_ld = '0; exp_req = 1'b0; exp_stall = 1'b0; exp_lv = 1'b0; exp_fault = 2'b00;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    en = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "bench watchdog");
  end
endmodule
